// File: rtl/booth_mul_arbiter.sv
// Round-robin front end that time-shares one serial-operand Booth multiplier among N requesters.
// Operands go out multiplicand-then-multiplier; the product returns with a one-cycle ack.
module booth_mul_arbiter #(
  parameter int N       = 4,
  parameter int W       = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N*W-1:0]   op_a,
  input  logic [N*W-1:0]   op_b,
  output logic [N-1:0]     gnt,
  output logic [N-1:0]     ack,
  output logic [2*W-1:0]   result,
  output logic             err,
  output logic             busy,
  output logic [W-1:0]     mul_data,
  output logic             mul_start,
  input  logic             mul_done,
  input  logic [2*W-1:0]   mul_prod
);

  localparam int SW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE_M,
    S_ISSUE_Q,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [SW-1:0]   r_sel;
  logic [SW-1:0]   r_rr_ptr;
  logic [CW-1:0]   r_cnt;
  logic [2*W-1:0]  r_result;
  logic            r_timeout;

  logic [SW-1:0]   w_win;
  logic            w_hit_done;
  logic            w_hit_to;
  logic [N-1:0]    w_sel_oh;
  logic [SW-1:0]   w_ptr_next;

  // Scan requesters starting at the round-robin pointer, wrapping modulo N.
  always_comb begin : arb
    int idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    w_win = '0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(r_rr_ptr) + k) % N;
      if (!found && req[idx]) begin
        found = 1'b1;
        w_win = SW'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A done seen while the counter is still zero is left over from the previous operation.
  always_comb begin
    w_state_next = r_state;
    w_hit_done   = 1'b0;
    w_hit_to     = 1'b0;
    case (r_state)
      S_IDLE:    if (|req) w_state_next = S_ISSUE_M;
      S_ISSUE_M: w_state_next = S_ISSUE_Q;
      S_ISSUE_Q: w_state_next = S_WAIT;
      S_WAIT: begin
        if (mul_done && (r_cnt != '0)) begin
          w_state_next = S_RESP;
          w_hit_done   = 1'b1;
        end else if (r_cnt == CW'(TIMEOUT - 1)) begin
          w_state_next = S_RESP;
          w_hit_to     = 1'b1;
        end
      end
      S_RESP:    w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  assign w_sel_oh   = N'(1) << r_sel;
  assign w_ptr_next = (r_sel == SW'(N - 1)) ? '0 : r_sel + SW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel     <= '0;
      r_rr_ptr  <= '0;
      r_cnt     <= '0;
      r_result  <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (r_state == S_IDLE && (|req)) begin
        r_sel <= w_win;
      end
      if (r_state == S_ISSUE_Q) begin
        r_cnt <= '0;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_hit_done) begin
        r_result  <= mul_prod;
        r_timeout <= 1'b0;
      end else if (w_hit_to) begin
        r_result  <= '0;
        r_timeout <= 1'b1;
      end
      if (w_hit_done || w_hit_to) begin
        r_rr_ptr <= w_ptr_next;
      end
    end
  end

  // Outputs decode from registered state so reset clears them immediately.
  always_comb begin
    mul_data = '0;
    case (r_state)
      S_ISSUE_M:      mul_data = op_a[int'(r_sel)*W +: W];
      S_ISSUE_Q,
      S_WAIT:         mul_data = op_b[int'(r_sel)*W +: W];
      default:        mul_data = '0;
    endcase
  end

  assign busy      = (r_state != S_IDLE);
  assign gnt       = busy ? w_sel_oh : '0;
  assign ack       = (r_state == S_RESP) ? w_sel_oh : '0;
  assign err       = (r_state == S_RESP) && r_timeout;
  assign mul_start = (r_state == S_ISSUE_M);
  assign result    = r_result;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Directed bench for booth_mul_arbiter: acts as the multiplier and checks each
// completion against a scoreboard of expected products.
module tb_booth_mul_arbiter;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int TO = 64;

  logic             clk;
  logic             rst;
  logic [N-1:0]     req;
  logic [N*W-1:0]   op_a;
  logic [N*W-1:0]   op_b;
  logic [N-1:0]     gnt;
  logic [N-1:0]     ack;
  logic [2*W-1:0]   result;
  logic             err;
  logic             busy;
  logic [W-1:0]     mul_data;
  logic             mul_start;
  logic             mul_done;
  logic [2*W-1:0]   mul_prod;

  booth_mul_arbiter #(.N(N), .W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b),
    .gnt(gnt), .ack(ack), .result(result), .err(err), .busy(busy),
    .mul_data(mul_data), .mul_start(mul_start),
    .mul_done(mul_done), .mul_prod(mul_prod)
  );

  typedef struct {
    int            sel;
    logic [2*W-1:0] res;
    logic          err;
  } exp_t;

  exp_t        sb[$];
  logic [W-1:0] a_v[N];
  logic [W-1:0] b_v[N];
  int          errors = 0;
  int          checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2*W-1:0] sprod(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] sa;
    logic signed [2*W-1:0] sb_;
    sa  = $signed(a);
    sb_ = $signed(b);
    return sa * sb_;
  endfunction

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    a_v[i] = a;
    b_v[i] = b;
    op_a[i*W +: W] = a;
    op_b[i*W +: W] = b;
  endtask

  task automatic run_op(input logic [N-1:0] req_in, input int exp_sel, input int lat,
                        input bit stale, input bit hang, input logic [N-1:0] req_after,
                        input bit drop);
    bit           got;
    int           cyc;
    int           dl;
    logic [W-1:0] cap_a;
    logic [W-1:0] cap_b;
    exp_t         e;
    req = req_in;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (gnt != '0) got = 1'b1;
    end
    chk("grant_seen", 64'(got), 64'd1);
    if (!got) return;
    chk("gnt_onehot", 64'(gnt), 64'(N'(1) << exp_sel));
    chk("start_m", 64'(mul_start), 64'd1);
    chk("data_m", 64'(mul_data), 64'(a_v[exp_sel]));
    cap_a = mul_data;
    e.sel = exp_sel;
    e.res = hang ? '0 : sprod(a_v[exp_sel], b_v[exp_sel]);
    e.err = hang;
    sb.push_back(e);
    if (drop) req = req & ~(N'(1) << exp_sel);
    @(negedge clk);
    chk("start_q", 64'(mul_start), 64'd0);
    chk("data_q", 64'(mul_data), 64'(b_v[exp_sel]));
    cap_b = mul_data;
    if (stale) begin
      mul_done = 1'b1;
      mul_prod = 32'hDEADBEEF;
    end
    @(negedge clk);
    chk("busy_wait", 64'(busy), 64'd1);
    chk("data_w", 64'(mul_data), 64'(b_v[exp_sel]));
    dl  = stale ? lat + 1 : lat;
    got = 1'b0;
    cyc = 0;
    for (int c = 1; c <= TO + 4 && !got; c++) begin
      @(negedge clk);
      if (stale && c == 1) mul_done = 1'b0;
      if (ack != '0) begin
        got = 1'b1;
        cyc = c;
      end else if (!hang && c == dl) begin
        mul_done = 1'b1;
        mul_prod = sprod(cap_a, cap_b);
      end
    end
    chk("ack_seen", 64'(got), 64'd1);
    if (got && sb.size() > 0) begin
      e = sb.pop_front();
      chk("ack_onehot", 64'(ack), 64'(N'(1) << e.sel));
      chk("result", 64'(result), 64'(e.res));
      chk("err", 64'(err), 64'(e.err));
      chk("gnt_resp", 64'(gnt), 64'(N'(1) << e.sel));
      if (hang) chk("timeout_cycles", 64'(cyc), 64'(TO));
      $display("op sel=%0d result=0x%0h err=%0b cycles_in_wait=%0d", e.sel, result, err, cyc);
    end
    mul_done = 1'b0;
    req = req_after;
    @(negedge clk);
    chk("ack_off", 64'(ack), 64'd0);
    chk("gnt_off", 64'(gnt), 64'd0);
    chk("err_off", 64'(err), 64'd0);
  endtask

  initial begin
    bit g;
    rst = 1'b1; req = '0; op_a = '0; op_b = '0; mul_done = 1'b0; mul_prod = '0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_start", 64'(mul_start), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    set_op(0, 16'd14, 16'd10);
    run_op(4'b0001, 0, 3, 1'b0, 1'b0, 4'b0000, 1'b1);
    chk("result_140", 64'(result), 64'h8C);

    set_op(3, 16'hFFFD, 16'd7);
    run_op(4'b1000, 3, 2, 1'b0, 1'b0, 4'b0000, 1'b0);
    chk("result_neg21", 64'(result), 64'hFFFFFFEB);

    set_op(0, 16'h8000, 16'h8000);
    set_op(1, 16'h7FFF, 16'h7FFF);
    set_op(2, 16'hFFFF, 16'd5);
    set_op(3, 16'd1234, 16'hFFC8);
    run_op(4'b1111, 0, 1, 1'b0, 1'b0, 4'b1111, 1'b0);
    run_op(4'b1111, 1, 4, 1'b0, 1'b0, 4'b1111, 1'b0);
    run_op(4'b1111, 2, 2, 1'b0, 1'b0, 4'b1111, 1'b0);
    run_op(4'b1111, 3, 3, 1'b0, 1'b0, 4'b1111, 1'b0);
    run_op(4'b1111, 0, 1, 1'b0, 1'b0, 4'b1010, 1'b0);
    run_op(4'b1010, 1, 2, 1'b0, 1'b0, 4'b1010, 1'b0);
    run_op(4'b1010, 3, 2, 1'b0, 1'b0, 4'b1010, 1'b0);
    run_op(4'b1010, 1, 2, 1'b0, 1'b0, 4'b0000, 1'b0);

    set_op(0, 16'd21, 16'hFFFC);
    run_op(4'b0001, 0, 5, 1'b1, 1'b0, 4'b0000, 1'b0);

    set_op(2, 16'd9, 16'd9);
    run_op(4'b0100, 2, 0, 1'b0, 1'b1, 4'b0000, 1'b0);
    set_op(2, 16'd300, 16'd200);
    run_op(4'b0100, 2, 3, 1'b0, 1'b0, 4'b0000, 1'b0);

    // Abort mid-WAIT; pointer was 3, so after reset 1100 must pick requester 2.
    req = 4'b0100;
    g = 1'b0;
    for (int c = 0; c < 20 && !g; c++) begin
      @(negedge clk);
      if (gnt != '0) g = 1'b1;
    end
    chk("rst_test_grant", 64'(gnt), 64'b0100);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_gnt", 64'(gnt), 64'd0);
    chk("async_busy", 64'(busy), 64'd0);
    chk("async_start", 64'(mul_start), 64'd0);
    chk("async_data", 64'(mul_data), 64'd0);
    req = 4'b1100;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rst_no_ack", 64'(ack), 64'd0);
    end
    rst = 1'b0;
    set_op(2, 16'd77, 16'hFFFF);
    run_op(4'b1100, 2, 3, 1'b0, 1'b0, 4'b0000, 1'b0);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
